// File: rtl/gpu_pixel_writer.sv
// gpu_pixel_writer: clips decoder pixels, queues linear framebuffer addresses and drains them over req/ack.
// Optional GPU_PIXEL_WRITER_STATS_EN adds saturating written/clipped pixel counters.
module gpu_pixel_writer #(
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned ADDR_BITS     = 19,
    parameter int unsigned COLOR_BITS    = 24,
    parameter int unsigned WIDTH_BITS    = $clog2(SCREEN_WIDTH),
    parameter int unsigned HEIGHT_BITS   = $clog2(SCREEN_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [WIDTH_BITS-1:0] x_i,
    input  logic [HEIGHT_BITS-1:0] y_i,
    input  logic                  data_ready_i,
    input  logic [COLOR_BITS-1:0] color_i,
    output logic                  stall_o,
    output logic                  mem_wr_req_o,
    output logic [ADDR_BITS-1:0]  mem_addr_o,
    output logic [COLOR_BITS-1:0] mem_data_o,
    input  logic                  mem_ack_i,
    output logic                  overflow_o,
    output logic                  idle_o
`ifdef GPU_PIXEL_WRITER_STATS_EN
    ,
    output logic [15:0]           pix_written_o,
    output logic [15:0]           pix_clipped_o
`endif
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                state, state_n;
    logic [PW:0]           wptr, rptr;
    logic [ADDR_BITS-1:0]  addr_mem [FIFO_DEPTH];
    logic [COLOR_BITS-1:0] color_mem [FIFO_DEPTH];
    logic [ADDR_BITS-1:0]  addr;
    logic                  empty, full, clip, push, pop;

    // Pointers carry an extra wrap bit so full and empty differ only in the MSB
    assign empty   = wptr == rptr;
    assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign clip    = (32'(x_i) >= SCREEN_WIDTH) || (32'(y_i) >= SCREEN_HEIGHT);
    assign push    = data_ready_i && !full && !clip;
    assign addr    = ADDR_BITS'((ADDR_BITS+1)'(y_i) * (ADDR_BITS+1)'(SCREEN_WIDTH) + (ADDR_BITS+1)'(x_i));
    assign stall_o = full;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wptr[PW-1:0]]  <= addr;
            color_mem[wptr[PW-1:0]] <= color_i;
        end
    end

    always_comb begin
        pop     = (state == IDLE) && !empty;
        state_n = state;
        if (pop)
            state_n = WRITE;
        else if (state == WRITE && mem_ack_i)
            state_n = DONE;
        else if (state == DONE)
            state_n = IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            wptr         <= '0;
            rptr         <= '0;
            mem_wr_req_o <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            overflow_o   <= 1'b0;
            idle_o       <= 1'b1;
        end else begin
            state        <= state_n;
            wptr         <= wptr + (PW+1)'(push);
            rptr         <= rptr + (PW+1)'(pop);
            mem_wr_req_o <= state_n == WRITE;
            overflow_o   <= overflow_o || (data_ready_i && full);
            idle_o       <= empty && (state == IDLE);
            if (pop) begin
                mem_addr_o <= addr_mem[rptr[PW-1:0]];
                mem_data_o <= color_mem[rptr[PW-1:0]];
            end
        end
    end

`ifdef GPU_PIXEL_WRITER_STATS_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pix_written_o <= '0;
            pix_clipped_o <= '0;
        end else begin
            if (state == WRITE && mem_ack_i && pix_written_o != '1)
                pix_written_o <= pix_written_o + 16'd1;
            if (data_ready_i && !full && clip && pix_clipped_o != '1)
                pix_clipped_o <= pix_clipped_o + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_gpu_pixel_writer.sv
// tb_gpu_pixel_writer: directed and randomized checks of gpu_pixel_writer against a queue-based write model.
module tb_gpu_pixel_writer;
    localparam int W = 640;
    localparam int H = 480;

    typedef struct {
        int unsigned addr;
        logic [23:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic        dr = 1'b0;
    logic [23:0] color = '0;
    logic        stall, req, ack = 1'b0, ovf, idle;
    logic [18:0] addr;
    logic [23:0] data;
`ifdef GPU_PIXEL_WRITER_STATS_EN
    logic [15:0] pw, pc;
`endif

    wr_t         exp_q[$];
    wr_t         f;
    int          checks = 0, errors = 0, writes = 0, clipped = 0;
    int          max_wait = 0, wait_cnt = -1;
    bit          hold = 1'b0, exp_ovf = 1'b0;
    logic        prev_req = 1'b0;
    logic [18:0] prev_addr = '0;
    logic [23:0] prev_data = '0;

    always #5 clk = ~clk;

    gpu_pixel_writer dut (
        .clk(clk), .n_rst(n_rst), .x_i(x), .y_i(y), .data_ready_i(dr), .color_i(color),
        .stall_o(stall), .mem_wr_req_o(req), .mem_addr_o(addr), .mem_data_o(data),
        .mem_ack_i(ack), .overflow_o(ovf), .idle_o(idle)
`ifdef GPU_PIXEL_WRITER_STATS_EN
        , .pix_written_o(pw), .pix_clipped_o(pc)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SRAM controller model: random ack latency, completion checked against the expected write order
    always @(negedge clk) begin
        if (ack && !req) begin
            writes++;
            chk("spurious_write", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                f = exp_q.pop_front();
                chk("write_addr", addr, f.addr);
                chk("write_data", data, f.data);
            end
            ack = 1'b0;
            wait_cnt = -1;
        end else if (req) begin
            if (prev_req) begin
                chk("addr_stable", addr, prev_addr);
                chk("data_stable", data, prev_data);
            end
            if (!hold && !ack) begin
                if (wait_cnt < 0) wait_cnt = $urandom_range(0, max_wait);
                if (wait_cnt == 0) ack = 1'b1;
                else wait_cnt--;
            end
        end
        prev_req  = req;
        prev_addr = addr;
        prev_data = data;
    end

    task automatic drive(input int px, input int py, input logic [23:0] c, input bit honour);
        int g = 0;
        @(negedge clk);
        if (honour && stall) begin
            dr = 1'b0;
            while (stall && g < 200) begin
                @(negedge clk);
                g++;
            end
            chk("stall_release_timeout", g < 200, 1);
        end
        x = px[9:0];
        y = py[8:0];
        color = c;
        dr = 1'b1;
        if (stall) exp_ovf = 1'b1;
        else if (px < W && py < H) exp_q.push_back('{addr: py * W + px, data: c});
        else clipped++;
    endtask

    task automatic release_dr();
        @(negedge clk);
        dr = 1'b0;
    endtask

    task automatic wait_req();
        int g = 0;
        while (!req && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("req_timeout", req, 1);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || !idle) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        chk("drain_timeout", g < 2000, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        bit seen;
        #12;
        chk("rst_req", req, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data", data, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_idle", idle, 1);
`ifdef GPU_PIXEL_WRITER_STATS_EN
        chk("rst_pw", pw, 0);
        chk("rst_pc", pc, 0);
`endif
        @(negedge clk);
        n_rst = 1'b1;

        // single pixel, zero-wait ack
        max_wait = 0;
        drive(10, 2, 24'hFF0000, 0);
        release_dr();
        wait_req();
        chk("single_addr", addr, 1290);
        chk("single_data", data, 24'hFF0000);
        @(negedge clk);
        @(negedge clk);
        chk("single_idle_early", idle, 0);
        @(negedge clk);
        chk("single_idle_late", idle, 1);
        drain();
        chk("single_writes", writes, 1);

        // clipping
        w0 = writes;
        seen = 1'b0;
        drive(640, 0, 24'h123456, 0);
        drive(0, 480, 24'h654321, 0);
        release_dr();
        repeat (10) begin
            @(negedge clk);
            if (req) seen = 1'b1;
        end
        chk("clip_no_req", seen, 0);
        chk("clip_writes", writes - w0, 0);
        chk("clip_ovf", ovf, exp_ovf);
        chk("clip_count_model", clipped, 2);
`ifdef GPU_PIXEL_WRITER_STATS_EN
        chk("clip_pc", pc, 2);
`endif

        // backpressure: one write pending, then five pixels
        hold = 1'b1;
        w0 = writes;
        drive(5, 5, 24'($urandom), 0);
        release_dr();
        wait_req();
        for (int i = 0; i < 4; i++) drive(i, 1, 24'($urandom), 0);
        @(negedge clk);
        chk("bp_stall_after_4", stall, 1);
        chk("bp_ovf_before_5th", ovf, 0);
        x = 10'd7;
        y = 9'd7;
        dr = 1'b1;
        exp_ovf = 1'b1;
        @(negedge clk);
        dr = 1'b0;
        chk("bp_ovf_set", ovf, 1);
        chk("bp_stall_held", stall, 1);
        max_wait = 3;
        hold = 1'b0;
        drain();
        chk("bp_writes", writes - w0, 5);
        chk("bp_ovf_sticky", ovf, exp_ovf);

        // ordering with random ack latency
        max_wait = 5;
        w0 = writes;
        drive(0, 0, 24'hA00001, 0);
        drive(639, 479, 24'hA00002, 0);
        drive(1, 1, 24'hA00003, 0);
        release_dr();
        drain();
        chk("order_writes", writes - w0, 3);

        // reset mid-write with two entries queued
        hold = 1'b1;
        for (int i = 0; i < 3; i++) drive(20 + i, 3, 24'($urandom), 0);
        release_dr();
        chk("rmw_req_pending", req, 1);
        #2;
        n_rst = 1'b0;
        ack = 1'b0;
        #1;
        chk("rmw_req_async", req, 0);
        chk("rmw_idle", idle, 1);
        chk("rmw_stall", stall, 0);
        chk("rmw_ovf", ovf, 0);
        exp_q.delete();
        exp_ovf = 1'b0;
        hold = 1'b0;
        max_wait = 0;
        @(negedge clk);
        #2;
        n_rst = 1'b1;
        w0 = writes;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (req) seen = 1'b1;
        end
        chk("rmw_no_req", seen, 0);
        chk("rmw_no_writes", writes - w0, 0);
        chk("rmw_idle_after", idle, 1);

        // continuous in-bounds stream honouring stall
        max_wait = 2;
        w0 = writes;
        for (int i = 0; i < 20; i++)
            drive($urandom_range(0, W - 1), $urandom_range(0, H - 1), 24'($urandom), 1);
        release_dr();
        drain();
        chk("stream_writes", writes - w0, 20);
        chk("stream_ovf", ovf, exp_ovf);
`ifdef GPU_PIXEL_WRITER_STATS_EN
        chk("stream_pw", pw, 20);
        chk("stream_pc", pc, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
